// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit:
// opcode/func encodings, ALU operation codes, FSM states and decode results.
package mc_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operation codes seen by the datapath
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // FSM states; the numeric values are visible on the debug port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Instruction class produced by the decoder; drives FSM branching
  typedef enum logic [2:0] {
    IC_R     = 3'd0,
    IC_ORI   = 3'd1,
    IC_ADDIU = 3'd2,
    IC_LW    = 3'd3,
    IC_SW    = 3'd4,
    IC_BEQ   = 3'd5,
    IC_J     = 3'd6,
    IC_ILL   = 3'd7
  } iclass_t;

  // Datapath level controls that depend only on the instruction
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       extop;
    logic [2:0] aluop;
  } lvl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational decoder: op/func -> instruction class, level controls
// and an illegal-instruction flag. Holds no state.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output lvl_t       lvl,
  output logic       illegal
);

  logic       r_ok;
  logic [2:0] r_aluop;

  // Classify the instruction and derive its level controls
  always_comb begin
    r_ok    = 1'b1;
    r_aluop = ALU_ADD;
    case (func)
      FN_ADDU: r_aluop = ALU_ADD;
      FN_SUBU: r_aluop = ALU_SUB;
      FN_AND:  r_aluop = ALU_AND;
      FN_OR:   r_aluop = ALU_OR;
      FN_SLT:  r_aluop = ALU_SLT;
      default: r_ok    = 1'b0;
    endcase

    iclass = IC_ILL;
    case (op)
      OP_RTYPE: iclass = r_ok ? IC_R : IC_ILL;
      OP_ORI:   iclass = IC_ORI;
      OP_ADDIU: iclass = IC_ADDIU;
      OP_LW:    iclass = IC_LW;
      OP_SW:    iclass = IC_SW;
      OP_BEQ:   iclass = IC_BEQ;
      OP_J:     iclass = IC_J;
      default:  iclass = IC_ILL;
    endcase

    lvl = '0;
    case (iclass)
      IC_R: begin
        lvl.regdst = 1'b1;
        lvl.aluop  = r_aluop;
      end
      IC_ORI: begin
        // ori zero-extends its immediate, so extop stays 0
        lvl.alusrc = 1'b1;
        lvl.aluop  = ALU_OR;
      end
      IC_ADDIU: begin
        lvl.alusrc = 1'b1;
        lvl.extop  = 1'b1;
      end
      IC_LW: begin
        lvl.alusrc   = 1'b1;
        lvl.memtoreg = 1'b1;
        lvl.extop    = 1'b1;
      end
      IC_SW: begin
        lvl.alusrc = 1'b1;
        lvl.extop  = 1'b1;
      end
      IC_BEQ: begin
        lvl.extop = 1'b1;
        lvl.aluop = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign illegal = (iclass == IC_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/exec/mem/writeback,
// drives datapath controls, and counts retired instructions (pcwr pulses).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             irwr,
  output logic             pcwr,
  output logic             regwr,
  output logic             memwr,
  output logic             regdst,
  output logic             ALUsrc,
  output logic             memtoreg,
  output logic             branch,
  output logic             jump,
  output logic             extop,
  output logic [2:0]       ALUop,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_reg, state_next;
  logic [5:0]       op_reg, func_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [5:0] dec_op, dec_func;
  iclass_t    iclass;
  lvl_t       lvl;
  logic       illegal;
  logic       lvl_en;

  // In DECODE the live fields are decoded (they are being latched this
  // cycle); every later state works from the latched copy.
  assign dec_op   = (state_reg == ST_DECODE) ? op   : op_reg;
  assign dec_func = (state_reg == ST_DECODE) ? func : func_reg;

  mc_ctrl_decode u_decode (
    .op      (dec_op),
    .func    (dec_func),
    .iclass  (iclass),
    .lvl     (lvl),
    .illegal (illegal)
  );

  // Capture op/func while in DECODE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg   <= '0;
      func_reg <= '0;
    end else if (state_reg == ST_DECODE) begin
      op_reg   <= op;
      func_reg <= func;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and single-cycle strobes (ready inputs only matter in
  // FETCH and MEM)
  always_comb begin
    state_next = state_reg;
    irwr       = 1'b0;
    pcwr       = 1'b0;
    regwr      = 1'b0;
    memwr      = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (imem_rdy) begin
          irwr       = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (iclass == IC_J) begin
          pcwr       = 1'b1;
          jump       = 1'b1;
          state_next = ST_FETCH;
        end else if (illegal) begin
          if (ILLEGAL_HALT) begin
            state_next = ST_HALT;
          end else begin
            // Retire as a NOP: PC+4 and move on
            pcwr       = 1'b1;
            state_next = ST_FETCH;
          end
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (iclass)
          IC_LW, IC_SW: state_next = ST_MEM;
          IC_BEQ: begin
            // npc resolves taken/not-taken from the ALU zero flag
            branch     = 1'b1;
            pcwr       = 1'b1;
            state_next = ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_rdy) begin
          if (iclass == IC_SW) begin
            memwr      = 1'b1;
            pcwr       = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        regwr      = 1'b1;
        pcwr       = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Level controls are only driven while the instruction uses the datapath
  assign lvl_en   = (state_reg == ST_EXEC) || (state_reg == ST_MEM) ||
                    (state_reg == ST_WB);
  assign regdst   = lvl_en & lvl.regdst;
  assign ALUsrc   = lvl_en & lvl.alusrc;
  assign memtoreg = lvl_en & lvl.memtoreg;
  assign extop    = lvl_en & lvl.extop;
  assign ALUop    = lvl_en ? lvl.aluop : ALU_ADD;

  // Retired-instruction counter, one step per PC update, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (pcwr) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign instr_cnt = cnt_reg;
  assign state     = state_reg;
  assign halted    = (state_reg == ST_HALT);

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised bench for mc_ctrl: an instruction-level model builds the
// expected per-cycle outputs of every instruction, and a single compare
// process checks the DUT against them on each falling edge.
module tb_mc_ctrl;

  localparam int CNT_W = 32;

  // instruction classes used by the model
  localparam int C_R = 0, C_ORI = 1, C_ADDIU = 2, C_LW = 3, C_SW = 4,
                 C_BEQ = 5, C_J = 6, C_ILL = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [5:0]       op = '0, func = '0;
  logic             imem_rdy = 1'b0, dmem_rdy = 1'b0;
  logic             irwr, pcwr, regwr, memwr;
  logic             regdst, ALUsrc, memtoreg, branch, jump, extop;
  logic [2:0]       ALUop, state;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  mc_ctrl #(.ILLEGAL_HALT(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .irwr(irwr), .pcwr(pcwr), .regwr(regwr), .memwr(memwr),
    .regdst(regdst), .ALUsrc(ALUsrc), .memtoreg(memtoreg),
    .branch(branch), .jump(jump), .extop(extop), .ALUop(ALUop),
    .state(state), .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irwr, pcwr, regwr, memwr;
    logic [2:0] state;
    logic       halted;
    logic       lvl;      // compare the level controls this cycle
    logic       jchk;     // compare jump=1 this cycle
    logic       regdst, alusrc, memtoreg, branch, jump, extop;
    logic [2:0] aluop;
  } exp_t;

  exp_t        exp_c = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] mcnt = '0;
  int          checks = 0, failures = 0;
  logic        dmem_force = 1'b0;

  int memwr_n = 0, regwr_n = 0, s3_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Single compare process against the model's expectation for this cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("irwr", {31'b0, irwr}, {31'b0, exp_c.irwr});
      chk("pcwr", {31'b0, pcwr}, {31'b0, exp_c.pcwr});
      chk("regwr", {31'b0, regwr}, {31'b0, exp_c.regwr});
      chk("memwr", {31'b0, memwr}, {31'b0, exp_c.memwr});
      chk("state", {29'b0, state}, {29'b0, exp_c.state});
      chk("halted", {31'b0, halted}, {31'b0, exp_c.halted});
      chk("instr_cnt", instr_cnt, mcnt);
      if (exp_c.lvl) begin
        chk("regdst", {31'b0, regdst}, {31'b0, exp_c.regdst});
        chk("ALUsrc", {31'b0, ALUsrc}, {31'b0, exp_c.alusrc});
        chk("memtoreg", {31'b0, memtoreg}, {31'b0, exp_c.memtoreg});
        chk("branch", {31'b0, branch}, {31'b0, exp_c.branch});
        chk("jump", {31'b0, jump}, {31'b0, exp_c.jump});
        chk("extop", {31'b0, extop}, {31'b0, exp_c.extop});
        chk("ALUop", {29'b0, ALUop}, {29'b0, exp_c.aluop});
      end
      if (exp_c.jchk) chk("jump_j", {31'b0, jump}, 32'd1);
    end
  end

  // Event monitor used by the directed scenarios
  always @(negedge clk) begin
    memwr_n += int'(memwr);
    regwr_n += int'(regwr);
    s3_n    += int'(state == 3'd3);
  end

  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: return (f == 6'h21 || f == 6'h23 || f == 6'h24 ||
                         f == 6'h25 || f == 6'h2a) ? C_R : C_ILL;
      6'b001101: return C_ORI;
      6'b001001: return C_ADDIU;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic exp_t base(input logic [2:0] s);
    exp_t e;
    e = '0;
    e.state  = s;
    e.halted = (s == 3'd5);
    return e;
  endfunction

  // Level controls as the instruction table defines them
  function automatic exp_t lvl_of(input int c, input logic [5:0] f, input exp_t ein);
    exp_t e;
    e = ein;
    e.lvl      = 1'b1;
    e.regdst   = (c == C_R);
    e.alusrc   = (c == C_ORI || c == C_ADDIU || c == C_LW || c == C_SW);
    e.memtoreg = (c == C_LW);
    e.extop    = (c == C_ADDIU || c == C_LW || c == C_SW || c == C_BEQ);
    e.branch   = (c == C_BEQ);
    e.jump     = 1'b0;
    case (c)
      C_R: case (f)
        6'h21: e.aluop = 3'd0;
        6'h23: e.aluop = 3'd1;
        6'h24: e.aluop = 3'd2;
        6'h25: e.aluop = 3'd3;
        default: e.aluop = 3'd4;
      endcase
      C_ORI: e.aluop = 3'd3;
      C_BEQ: e.aluop = 3'd1;
      default: e.aluop = 3'd0;
    endcase
    return e;
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic dn();
    return dmem_force ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: apply inputs and this cycle's expectation
  task automatic cyc(input exp_t e, input logic [5:0] o, input logic [5:0] f,
                     input logic ir, input logic dr);
    op = o; func = f; imem_rdy = ir; dmem_rdy = dr;
    exp_c = e; exp_valid = 1'b1;
    @(posedge clk); #1;
    if (e.pcwr) mcnt = mcnt + 32'd1;
  endtask

  // Expected cycle timeline of one instruction; op/func are only valid in
  // DECODE, everything else the bench randomises to prove it is ignored.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int w1, input int w2, output int n);
    int   c;
    exp_t e;
    c = cls_of(o, f);
    n = 0;
    for (int i = 0; i < w1; i++) begin
      cyc(base(3'd0), r6(), r6(), 1'b0, dn()); n++;
    end
    e = base(3'd0); e.irwr = 1'b1;
    cyc(e, r6(), r6(), 1'b1, dn()); n++;
    e = base(3'd1);
    if (c == C_J) begin
      e.pcwr = 1'b1; e.jchk = 1'b1;
      cyc(e, o, f, rb(), dn()); n++;
      return;
    end
    cyc(e, o, f, rb(), dn()); n++;
    if (c == C_ILL) return;
    e = lvl_of(c, f, base(3'd2));
    if (c == C_BEQ) begin
      e.pcwr = 1'b1;
      cyc(e, r6(), r6(), rb(), dn()); n++;
      return;
    end
    cyc(e, r6(), r6(), rb(), dn()); n++;
    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i < w2; i++) begin
        cyc(lvl_of(c, f, base(3'd3)), r6(), r6(), rb(), 1'b0); n++;
      end
      e = lvl_of(c, f, base(3'd3));
      if (c == C_SW) begin
        e.memwr = 1'b1; e.pcwr = 1'b1;
        cyc(e, r6(), r6(), rb(), 1'b1); n++;
        return;
      end
      cyc(e, r6(), r6(), rb(), 1'b1); n++;
    end
    e = lvl_of(c, f, base(3'd4));
    e.regwr = 1'b1; e.pcwr = 1'b1;
    cyc(e, r6(), r6(), rb(), dn()); n++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_irwr"}, {31'b0, irwr}, 32'd0);
    chk({tag, "_pcwr"}, {31'b0, pcwr}, 32'd0);
    chk({tag, "_regwr"}, {31'b0, regwr}, 32'd0);
    chk({tag, "_memwr"}, {31'b0, memwr}, 32'd0);
    chk({tag, "_lvl"}, {26'b0, regdst, ALUsrc, memtoreg, branch, jump, extop}, 32'd0);
    chk({tag, "_ALUop"}, {29'b0, ALUop}, 32'd0);
    chk({tag, "_state"}, {29'b0, state}, 32'd0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
    chk({tag, "_cnt"}, instr_cnt, 32'd0);
  endtask

  // Assert reset mid-cycle, check async effect, then release cleanly
  task automatic async_reset(input string tag);
    exp_valid = 1'b0;
    imem_rdy  = 1'b0;
    #3 rst = 1'b0;
    #1 chk_reset(tag);
    dmem_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    mcnt = '0;
    @(posedge clk); #1;
  endtask

  logic [5:0] t_op [10];
  logic [5:0] t_fn [10];

  initial begin
    int n, k, m0, m1, s0;
    logic [31:0] c0;
    exp_t e;

    t_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h09, 6'h23, 6'h2b, 6'h04};
    t_fn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    // reset state
    repeat (3) @(posedge clk);
    #2 chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // addu with ready high
    run_instr(6'b000000, 6'b100001, 0, 0, n);
    chk("addu_len", n, 4);
    chk("addu_cnt", instr_cnt, 32'd1);

    // lw with three wait cycles in MEM
    s0 = s3_n; m1 = regwr_n;
    run_instr(6'b100011, 6'h00, 0, 3, n);
    chk("lw_len", n, 8);
    chk("lw_mem_cycles", s3_n - s0, 4);
    chk("lw_regwr", regwr_n - m1, 1);

    // sw with dmem_rdy held high across it and the following j
    dmem_force = 1'b1;
    m0 = memwr_n; m1 = regwr_n;
    run_instr(6'b101011, 6'h00, 0, 0, n);
    chk("sw_len", n, 4);
    run_instr(6'b000010, r6(), 0, 0, n);
    dmem_force = 1'b0;
    chk("sw_memwr_pulses", memwr_n - m0, 1);
    chk("sw_regwr_pulses", regwr_n - m1, 0);

    // beq then j
    c0 = instr_cnt;
    run_instr(6'b000100, r6(), 0, 0, n);
    chk("beq_len", n, 3);
    run_instr(6'b000010, r6(), 0, 0, n);
    chk("j_len", n, 2);
    chk("bj_cnt", instr_cnt - c0, 32'd2);

    // randomised instruction stream with random ready stalls
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 10);
      if (k == 10) run_instr(6'b000010, r6(), $urandom_range(0, 3), 0, n);
      else run_instr(t_op[k], (t_op[k] == 6'h00) ? t_fn[k] : r6(),
                     $urandom_range(0, 3), $urandom_range(0, 3), n);
    end

    // reset during MEM of sw, before dmem_rdy
    e = base(3'd0); e.irwr = 1'b1;
    cyc(e, r6(), r6(), 1'b1, 1'b0);
    cyc(base(3'd1), 6'b101011, r6(), rb(), 1'b0);
    cyc(lvl_of(C_SW, 6'h00, base(3'd2)), r6(), r6(), rb(), 1'b0);
    cyc(lvl_of(C_SW, 6'h00, base(3'd3)), r6(), r6(), rb(), 1'b0);
    m0 = memwr_n;
    async_reset("rst_mem");
    chk("rst_mem_memwr", memwr_n - m0, 0);
    chk("rst_mem_state", {29'b0, state}, 32'd0);
    run_instr(6'b001101, r6(), 1, 0, n);

    // illegal opcode halts until reset
    run_instr(6'b111111, r6(), 0, 0, n);
    for (int i = 0; i < 20; i++) cyc(base(3'd5), r6(), r6(), rb(), rb());
    async_reset("rst_halt");
    run_instr(6'b001001, r6(), 0, 0, n);
    chk("post_halt_cnt", instr_cnt, 32'd1);

    exp_valid = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
